uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_MAX_REQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_ACK
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts one above ptr_i.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = PW'((int'(ptr_i) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                grant_o[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_WATCHDOG_EN to add a WAIT_DONE timeout that forces ACK.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*UART_DATA_W-1:0] data_i,
    input  logic                           tx_done_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [UART_DATA_W-1:0]         data_o,
    output logic                           load_byte_o,
    output logic                           t_byte_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > UART_MAX_REQ || TIMEOUT_CYCLES == 16'd0) begin : g_cfg_err
        $error("uart_tx_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t             r_state;
    arb_state_t             w_next;
    logic [NUM_REQ-1:0]     r_gnt;
    logic [UART_DATA_W-1:0] r_data;
    logic [PW-1:0]          r_ptr;
    logic [NUM_REQ-1:0]     w_grant;
    logic [UART_DATA_W-1:0] w_sel_byte;
    logic [PW-1:0]          w_win_idx;
    logic                   w_wd_expire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .grant_o (w_grant)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_byte = data_i[k*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_gnt[k]) begin
                w_win_idx = PW'(k);
            end
        end
    end

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [15:0] r_wd_cnt;
    logic        r_timeout;

    assign w_wd_expire = (r_state == ST_WAIT_DONE) && !tx_done_i
                       && (r_wd_cnt == TIMEOUT_CYCLES - 16'd1);

    // Count restarts on the START->WAIT_DONE edge so each byte gets a full budget
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire;
            if (r_state == ST_START) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD:  w_next = ST_START;
            ST_START: w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done_i || w_wd_expire) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grant and byte are frozen from IDLE until ACK; pointer moves on ACK exit
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_gnt  <= '0;
            r_data <= '0;
            r_ptr  <= PW'(NUM_REQ - 1);
        end else if (r_state == ST_IDLE && |req_i) begin
            r_gnt  <= w_grant;
            r_data <= w_sel_byte;
        end else if (r_state == ST_ACK) begin
            r_gnt  <= '0;
            r_ptr  <= w_win_idx;
        end
    end

    assign gnt_o       = r_gnt;
    assign ack_o       = (r_state == ST_ACK) ? r_gnt : '0;
    assign data_o      = r_data;
    assign load_byte_o = (r_state == ST_LOAD);
    assign t_byte_o    = (r_state == ST_START);
    assign busy_o      = (r_state != ST_IDLE);

endmodule
